// File: rtl/ahb_slave_mem_if.sv
// AHB-lite bus bundle between one master and the single memory slave.
// Latency: none (wires only). Backpressure: HREADY driven by the slave, honoured by the master.
// Backpressure behaviour: address/control are only sampled while HREADY is high.
interface ahb_slave_mem_if;
    logic        HSEL;
    logic [7:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// 64 x 32-bit AHB-lite memory slave with byte-lane writes and two-cycle ERROR responses.
// Latency: WAIT_STATES wait cycles then one data cycle per beat; errors take two cycles.
// Backpressure: HREADY low during wait states and the first error cycle; pipelined beats otherwise.
module ahb_slave_mem #(
    parameter int WAIT_STATES = 1
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    ahb_slave_mem_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q,  addr_d;
    logic [2:0]  size_q,  size_d;
    logic        write_q, write_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic [31:0] mem_q [64];

    logic        hready;
    logic        hresp;
    logic        accept;
    logic        illegal;
    logic        wr_en;
    logic [5:0]  wr_idx;
    logic [3:0]  lane_mask;
    logic [31:0] mem_word_d;
    logic        unused_ok;

    // Burst type and the BUSY/IDLE distinction carry no meaning for a beat-by-beat slave.
    assign unused_ok = ^{bus.HBURST, bus.HTRANS[0]};

    assign accept  = bus.HSEL & bus.HTRANS[1] & hready;
    assign illegal = (bus.HSIZE > 3'b010)
                   | ((bus.HSIZE == 3'b001) & bus.HADDR[0])
                   | ((bus.HSIZE == 3'b010) & (|bus.HADDR[1:0]));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all present HREADY=1, so a new beat may start here.
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d  = bus.HADDR;
                    size_d  = bus.HSIZE;
                    write_d = bus.HWRITE;
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 2'(WAIT_STATES - 1);
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wr_en  = (state_q == ST_DATA) & write_q;
    assign wr_idx = addr_q[7:2];

    always_comb begin
        lane_mask = 4'b1111;
        case (size_q[1:0])
            2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
            2'b01:   lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    always_comb begin
        mem_word_d = mem_q[wr_idx];
        for (int l = 0; l < 4; l++) begin
            if (lane_mask[l]) begin
                mem_word_d[8*l +: 8] = bus.HWDATA[8*l +: 8];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= mem_word_d;
        end
    end

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        case (state_q)
            ST_WAIT: hready = 1'b0;
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
            default: begin
                hready = 1'b1;
                hresp  = 1'b0;
            end
        endcase
    end

    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;
    // Read data is combinational from the array, so a write retired on the previous edge is visible.
    assign bus.HRDATA = ((state_q == ST_DATA) && !write_q) ? mem_q[addr_q[7:2]] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Drives two slaves (0 and 2 wait states) from one bus stimulus and checks both against a beat-schedule model.
module tb_ahb_slave_mem;

    logic        hclk;
    logic        hresetn;
    logic        hsel;
    logic [7:0]  haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;

    int checks = 0;
    int errors = 0;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    ahb_slave_mem_if if0 ();
    ahb_slave_mem_if if2 ();

    assign if0.HSEL = hsel;   assign if2.HSEL = hsel;
    assign if0.HADDR = haddr; assign if2.HADDR = haddr;
    assign if0.HTRANS = htrans; assign if2.HTRANS = htrans;
    assign if0.HWRITE = hwrite; assign if2.HWRITE = hwrite;
    assign if0.HSIZE = hsize; assign if2.HSIZE = hsize;
    assign if0.HBURST = hburst; assign if2.HBURST = hburst;
    assign if0.HWDATA = hwdata; assign if2.HWDATA = hwdata;

    ahb_slave_mem #(.WAIT_STATES(0)) u_dut0 (.HCLK(hclk), .HRESETn(hresetn), .bus(if0));
    ahb_slave_mem #(.WAIT_STATES(2)) u_dut2 (.HCLK(hclk), .HRESETn(hresetn), .bus(if2));

    // ---------------- reference model: each accepted beat becomes a list of expected cycles
    typedef struct packed {
        logic       rdy;
        logic       resp;
        logic       dat;
        logic       wr;
        logic [7:0] addr;
        logic [2:0] size;
    } ent_t;

    ent_t        sq [2][$];
    logic [31:0] mmem [2][64];

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic logic [33:0] dut_out(input int k);
        if (k == 0) return {if0.HREADY, if0.HRESP, if0.HRDATA};
        return {if2.HREADY, if2.HRESP, if2.HRDATA};
    endfunction

    function automatic logic is_legal(input logic [7:0] a, input logic [2:0] sz);
        if (sz > 3'd2) return 1'b0;
        if (sz == 3'd1 && a[0] != 1'b0) return 1'b0;
        if (sz == 3'd2 && a[1:0] != 2'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            sq[k].delete();
            for (int i = 0; i < 64; i++) mmem[k][i] = 32'h0;
        end
    endtask

    task automatic push_sched(input int k, input logic wr, input logic [7:0] a, input logic [2:0] sz);
        ent_t e;
        if (is_legal(a, sz)) begin
            for (int w = 0; w < ws_of(k); w++) begin
                e = '{rdy: 1'b0, resp: 1'b0, dat: 1'b0, wr: wr, addr: a, size: sz};
                sq[k].push_back(e);
            end
            e = '{rdy: 1'b1, resp: 1'b0, dat: 1'b1, wr: wr, addr: a, size: sz};
            sq[k].push_back(e);
        end else begin
            e = '{rdy: 1'b0, resp: 1'b1, dat: 1'b0, wr: wr, addr: a, size: sz};
            sq[k].push_back(e);
            e = '{rdy: 1'b1, resp: 1'b1, dat: 1'b0, wr: wr, addr: a, size: sz};
            sq[k].push_back(e);
        end
    endtask

    task automatic apply_write(input int k, input logic [7:0] a, input logic [2:0] sz, input logic [31:0] wd);
        logic sel;
        for (int l = 0; l < 4; l++) begin
            if (sz == 3'd0)      sel = (l == int'(a[1:0]));
            else if (sz == 3'd1) sel = ((l / 2) == int'(a[1]));
            else                 sel = 1'b1;
            if (sel) mmem[k][a[7:2]][8*l +: 8] = wd[8*l +: 8];
        end
    endtask

    always @(negedge hresetn) model_clear();

    always @(posedge hclk) begin
        logic cur_rdy;
        ent_t e;
        if (hresetn) begin
            for (int k = 0; k < 2; k++) begin
                cur_rdy = 1'b1;
                if (sq[k].size() > 0) begin
                    e = sq[k].pop_front();
                    cur_rdy = e.rdy;
                    if (e.dat && e.wr) apply_write(k, e.addr, e.size, hwdata);
                end
                if (cur_rdy && hsel && htrans[1]) push_sched(k, hwrite, haddr, hsize);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Per-cycle compare of both slaves against the model.
    always @(negedge hclk) begin
        logic [33:0] o;
        logic        er, ep;
        logic [31:0] ed;
        ent_t        e;
        for (int k = 0; k < 2; k++) begin
            er = 1'b1; ep = 1'b0; ed = 32'h0;
            if (hresetn && sq[k].size() > 0) begin
                e  = sq[k][0];
                er = e.rdy;
                ep = e.resp;
                if (e.dat && !e.wr) ed = mmem[k][e.addr[7:2]];
            end
            o = dut_out(k);
            chk($sformatf("dut%0d HREADY", 2*k), {31'h0, o[33]}, {31'h0, er});
            chk($sformatf("dut%0d HRESP", 2*k),  {31'h0, o[32]}, {31'h0, ep});
            chk($sformatf("dut%0d HRDATA", 2*k), o[31:0], ed);
        end
    end

    // ---------------- stimulus helpers
    task automatic bus_idle(input int n);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; haddr = 8'h0;
        for (int i = 0; i < n; i++) begin
            @(posedge hclk); #1;
        end
    endtask

    task automatic xfer(input int k, input logic wr, input logic [7:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output int nlow,
                        output logic resp_low, output logic resp_fin);
        logic [33:0] o;
        logic        done;
        int          c;
        hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz; hburst = 3'd0; hwdata = 32'h0;
        @(posedge hclk); #1;
        htrans = 2'b00; hwdata = wd;
        haddr = 8'($urandom); hwrite = 1'($urandom); hsize = 3'($urandom);
        nlow = 0; resp_low = 1'b0; resp_fin = 1'b0; rd = 32'h0; done = 1'b0; c = 0;
        while (!done && c < 12) begin
            @(negedge hclk);
            o = dut_out(k);
            if (o[33]) begin
                done = 1'b1; resp_fin = o[32]; rd = o[31:0];
            end else begin
                nlow++; resp_low = resp_low | o[32];
            end
            @(posedge hclk); #1;
            c++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL xfer timeout: dut%0d addr 0x%h, no HREADY within 12 cycles", 2*k, a);
        end
        hsel = 1'b0; hwrite = 1'b0; hsize = 3'd0; haddr = 8'h0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence
    initial begin
        logic [31:0] lits [4];
        logic [31:0] rd;
        int          nlow;
        logic        rl, rf;

        lits[0] = 32'h11111111; lits[1] = 32'h22222222;
        lits[2] = 32'h33333333; lits[3] = 32'h44444444;
        model_clear();
        hresetn = 1'b0; hwdata = 32'h0; hburst = 3'd0;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; haddr = 8'h0;

        @(negedge hclk);
        chk("reset dut0 HREADY", {31'h0, if0.HREADY}, 32'd1);
        chk("reset dut2 HRESP",  {31'h0, if2.HRESP},  32'd0);
        chk("reset dut2 HRDATA", if2.HRDATA, 32'h0);
        @(posedge hclk); #2 hresetn = 1'b1;
        @(posedge hclk); #1;

        // INCR4 write then INCR4 read on the zero-wait slave
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i <= 4; i++) begin
                if (i < 4) begin
                    hsel = 1'b1; htrans = (i == 0) ? 2'b10 : 2'b11; hwrite = (pass == 0);
                    haddr = 8'(8'h10 + 4*i); hsize = 3'd2; hburst = 3'b011;
                end else begin
                    htrans = 2'b00; hsel = 1'b0;
                end
                hwdata = (pass == 0 && i > 0) ? lits[i-1] : 32'h0;
                @(negedge hclk);
                if (i > 0) begin
                    chk("incr4 HREADY", {31'h0, if0.HREADY}, 32'd1);
                    chk("incr4 HRESP",  {31'h0, if0.HRESP},  32'd0);
                    if (pass == 1) chk($sformatf("incr4 read beat %0d", i-1), if0.HRDATA, lits[i-1]);
                end
                @(posedge hclk); #1;
            end
        end
        bus_idle(6);

        // two-wait single transfers
        xfer(1, 1'b1, 8'h20, 3'd2, 32'hDEADBEEF, rd, nlow, rl, rf);
        chk("ws2 write wait cycles", nlow, 32'd2);
        chk("ws2 write resp", {31'h0, rf}, 32'd0);
        xfer(1, 1'b0, 8'h20, 3'd2, 32'h0, rd, nlow, rl, rf);
        chk("ws2 read wait cycles", nlow, 32'd2);
        chk("ws2 read data", rd, 32'hDEADBEEF);
        bus_idle(4);

        // byte and halfword lane merge
        xfer(0, 1'b0, 8'h24, 3'd2, 32'h0, rd, nlow, rl, rf);
        chk("word 0x24 initial", rd, 32'h0);
        xfer(0, 1'b1, 8'h25, 3'd0, 32'h5A5AAB5A, rd, nlow, rl, rf);
        xfer(0, 1'b1, 8'h26, 3'd1, 32'h12345A5A, rd, nlow, rl, rf);
        xfer(0, 1'b0, 8'h24, 3'd2, 32'h0, rd, nlow, rl, rf);
        chk("lane merge 0x24", rd, 32'h1234AB00);

        // error responses
        xfer(0, 1'b1, 8'h30, 3'd2, 32'hCAFEF00D, rd, nlow, rl, rf);
        xfer(0, 1'b1, 8'h31, 3'd2, 32'h0BADBAD0, rd, nlow, rl, rf);
        chk("misaligned err low cycles", nlow, 32'd1);
        chk("misaligned err first resp", {31'h0, rl}, 32'd1);
        chk("misaligned err final resp", {31'h0, rf}, 32'd1);
        xfer(0, 1'b1, 8'h30, 3'd3, 32'h0BADBAD0, rd, nlow, rl, rf);
        chk("size3 err low cycles", nlow, 32'd1);
        chk("size3 err final resp", {31'h0, rf}, 32'd1);
        xfer(1, 1'b0, 8'h22, 3'd2, 32'h0, rd, nlow, rl, rf);
        chk("ws2 err ignores waits", nlow, 32'd1);
        chk("ws2 err rdata", rd, 32'h0);
        xfer(0, 1'b0, 8'h30, 3'd2, 32'h0, rd, nlow, rl, rf);
        chk("0x30 survives errors", rd, 32'hCAFEF00D);

        // unselected NONSEQ is a no-op
        hsel = 1'b0; htrans = 2'b10; hwrite = 1'b1; haddr = 8'h30; hsize = 3'd2;
        @(posedge hclk); #1;
        hsel = 1'b1; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
        @(negedge hclk);
        chk("hsel0 HREADY", {31'h0, if0.HREADY}, 32'd1);
        chk("hsel0 HRESP",  {31'h0, if0.HRESP},  32'd0);
        @(posedge hclk); #1;
        xfer(0, 1'b0, 8'h30, 3'd2, 32'h0, rd, nlow, rl, rf);
        chk("0x30 after hsel0", rd, 32'hCAFEF00D);

        // BUSY inserted between beats of an INCR burst
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 8'h50; hsize = 3'd2; hburst = 3'b001;
        @(posedge hclk); #1;
        htrans = 2'b01; haddr = 8'h54; hwdata = 32'hA5A5A5A5;
        @(posedge hclk); #1;
        htrans = 2'b11; hwdata = 32'h0;
        @(negedge hclk);
        chk("busy HREADY", {31'h0, if0.HREADY}, 32'd1);
        chk("busy HRESP",  {31'h0, if0.HRESP},  32'd0);
        @(posedge hclk); #1;
        htrans = 2'b00; hsel = 1'b0; hwdata = 32'h5A5A0001;
        @(posedge hclk); #1;
        xfer(0, 1'b0, 8'h50, 3'd2, 32'h0, rd, nlow, rl, rf);
        chk("busy burst beat0", rd, 32'hA5A5A5A5);
        xfer(0, 1'b0, 8'h54, 3'd2, 32'h0, rd, nlow, rl, rf);
        chk("busy burst beat1", rd, 32'h5A5A0001);
        bus_idle(6);

        // reset in the middle of a waited write
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 8'h40; hsize = 3'd2;
        @(posedge hclk); #1;
        htrans = 2'b00; hsel = 1'b0; hwdata = 32'h12345678;
        #2 hresetn = 1'b0;
        #1;
        chk("mid-reset HREADY", {31'h0, if2.HREADY}, 32'd1);
        chk("mid-reset HRESP",  {31'h0, if2.HRESP},  32'd0);
        @(posedge hclk); @(posedge hclk); #2 hresetn = 1'b1;
        @(posedge hclk); #1;
        xfer(1, 1'b0, 8'h40, 3'd2, 32'h0, rd, nlow, rl, rf);
        chk("0x40 after reset", rd, 32'h0);
        chk("post-reset wait cycles", nlow, 32'd2);

        // random traffic, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            hsel   = ($urandom_range(0, 99) < 85);
            htrans = 2'($urandom);
            hwrite = 1'($urandom);
            hburst = 3'($urandom);
            hwdata = $urandom;
            hsize  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            haddr  = 8'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (hsize == 3'd1) haddr[0] = 1'b0;
                if (hsize == 3'd2) haddr[1:0] = 2'b00;
            end
            @(posedge hclk); #1;
        end
        bus_idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
